// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_ctrl
//  Description : CPU-to-memory bus cycle controller. Latches an access
//                request, lets the address decoder settle, then drives a
//                read or write strobe for a region-dependent number of wait
//                states. It finishes with a one-cycle ack, which carries an
//                error flag when the decode is bad.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_ctrl #(
    parameter int WS_ROM = 2,
    parameter int WS_RAM = 0,
    parameter int WS_VR  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [19:0] addr,
    input  logic [3:0]  cs_ram,
    input  logic        cs_rom,
    input  logic        cs_vr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  cpu_rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    // The wait counter only needs enough bits for the largest wait-state count.
    localparam int c_WS_MAX_A = (WS_ROM > WS_RAM) ? WS_ROM : WS_RAM;
    localparam int c_WS_MAX   = (c_WS_MAX_A > WS_VR) ? c_WS_MAX_A : WS_VR;
    localparam int c_CNT_W    = (c_WS_MAX < 1) ? 1 : $clog2(c_WS_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 r_we;
    logic [5:0]           w_sel;
    logic                 w_sel_ok;
    logic [c_CNT_W-1:0]   w_ws_load;
    logic                 w_last_access;

    assign w_sel         = {cs_ram, cs_rom, cs_vr};
    assign w_sel_ok      = $onehot(w_sel);
    assign w_last_access = (r_state == ACCESS) && (r_cnt == '0);

    // Pick the wait-state count of the selected region. The result is only
    // used when exactly one select is active.
    always_comb begin
        w_ws_load = c_CNT_W'(WS_RAM);
        if (cs_rom) begin
            w_ws_load = c_CNT_W'(WS_ROM);
        end else if (cs_vr) begin
            w_ws_load = c_CNT_W'(WS_VR);
        end
    end

    // State, wait counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic: decode check in SETUP, wait-state countdown in ACCESS.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = SETUP;
                    w_err_nxt   = 1'b0;
                end
            end
            SETUP: begin
                if (w_sel_ok) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = w_ws_load;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_err_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture in IDLE and read-data capture on the last strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= 20'h00000;
            mem_wdata <= 8'h00;
            r_we      <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            if ((r_state == IDLE) && req) begin
                addr      <= cpu_addr;
                mem_wdata <= cpu_wdata;
                r_we      <= we;
            end
            if (w_last_access && !r_we) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // Strobes and status are decoded from the state register, so an
    // asynchronous reset releases them at once.
    assign rd_n = !((r_state == ACCESS) && !r_we);
    assign wr_n = !((r_state == ACCESS) &&  r_we);
    assign ack  = (r_state == DONE);
    assign err  = (r_state == DONE) && r_err;
    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter WS_ROM, default 2, giving the wait states added to a ROM access.
REQ-002 The block SHALL have parameter WS_RAM, default 0, giving the wait states added to an access to any of the four RAM banks.
REQ-003 The block SHALL have parameter WS_VR, default 1, giving the wait states added to a video RAM access.
REQ-004 One clock, clk, SHALL be provided; reset is asynchronous and active-high.
REQ-005 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  CPU access request, sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- cpu_addr  input  20  CPU address; sampled with req.
- cpu_wdata  input  8  write data; sampled with req.
- addr  output  20  registered address driven to the address decoder and the memories.
- cs_ram  input  4  RAM bank selects returned by the address decoder.
- cs_rom  input  1  ROM select returned by the decoder.
- cs_vr  input  1  VRAM select returned by the decoder.
- mem_rdata  input  8  memory read data.
- mem_wdata  output  8  registered write data.
- rd_n  output  1  active-low read strobe.
- wr_n  output  1  active-low write strobe.
- cpu_rdata  output  8  captured read data.
- ack  output  1  single-cycle completion pulse.
- err  output  1  decode error flag, valid while ack = 1.
- busy  output  1  high whenever the state is not IDLE.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and DONE.
REQ-007 In IDLE with req = 1 at a clock edge, the block SHALL latch cpu_addr into addr, cpu_wdata into mem_wdata and we into an internal register, then enter SETUP.
REQ-008 In SETUP, rd_n and wr_n SHALL stay high; the block samples cs_ram, cs_rom and cs_vr (decoder is combinational off addr).
REQ-009 In SETUP, exactly one select active SHALL load the wait counter from that region's parameter and enter ACCESS.
REQ-010 In SETUP, zero selects or more than one select active SHALL cause the next state to be DONE with err = 1, and no strobe SHALL be asserted.
REQ-011 In ACCESS, rd_n (read) or wr_n (write) SHALL be low for exactly WS+1 consecutive cycles; the counter decrements each cycle and the block leaves ACCESS when the counter is 0.
REQ-012 On a read, at the clock edge ending the last ACCESS cycle, the block SHALL load mem_rdata into cpu_rdata.
REQ-013 On a write, cpu_rdata SHALL hold its previous value.
REQ-014 In DONE, the block SHALL assert ack = 1 for exactly one cycle with both strobes high, then return to IDLE.
REQ-015 Latency: if req is sampled at edge k, ack SHALL be high in cycle k+3+WS on a good access and in cycle k+2 on an error.
REQ-016 addr and mem_wdata SHALL remain stable from SETUP through DONE.
REQ-017 addr and mem_wdata SHALL hold their values in IDLE.
REQ-018 req SHALL be ignored while busy = 1, with no queueing.
REQ-019 A req sampled in the cycle ack is high SHALL be ignored.
REQ-020 The earliest accepted next request SHALL be the first IDLE cycle after DONE.
REQ-021 err SHALL be 0 except in the DONE cycle of a failed decode.
REQ-022 rd_n and wr_n SHALL never be low simultaneously.

Reset
REQ-023 While rst = 1, regardless of clk, the block SHALL force: state IDLE, addr 20'h00000, mem_wdata 0, cpu_rdata 0, rd_n 1, wr_n 1, ack 0, err 0, busy 0, wait counter 0.
REQ-024 A reset asserted in the middle of an access SHALL abort the access immediately, with no ack, and both strobes high in the same cycle.
REQ-025 After rst deasserts, the first req SHALL be accepted at the next rising edge.

Verification
REQ-026 Read from RAM #1 at 20'h04000 (WS_RAM = 0, mem_rdata = 8'hA5): rd_n low for 1 cycle, ack at k+3, cpu_rdata = 8'hA5, err = 0.
REQ-027 Read from ROM at 20'h03FFF (WS_ROM = 2): rd_n low for 3 cycles, ack at k+5, addr stable at 20'h03FFF throughout.
REQ-028 Write of 8'h3C to VRAM at 20'hF0000 (WS_VR = 1): wr_n low for 2 cycles, mem_wdata = 8'h3C, rd_n always high, cpu_rdata unchanged.
REQ-029 Decoder stub forcing cs_ram = 4'b0011 at 20'h40000: no strobe, ack at k+2 with err = 1.
REQ-030 Back-to-back requests: req held high continuously across reads at 20'h7FFFF then 20'h80000: second access starts only after DONE, with no overlap of strobes.
REQ-031 rst pulsed during the second ROM wait cycle: rd_n goes to 1 and busy to 0 without waiting for clk, no ack follows, and a new RAM read completes normally afterwards.
